// File: rtl/axis_sample_pkg.sv
// Shared constants and types for the AXI-Stream sample packer.
package axis_sample_pkg;

  localparam int unsigned S_TDATA_WIDTH_DEF = 32;
  localparam int unsigned M_TDATA_WIDTH_DEF = 2 * S_TDATA_WIDTH_DEF;
  localparam int unsigned FIFO_DEPTH        = 2;
  localparam int unsigned FIFO_CNT_WIDTH    = 2;
  localparam int unsigned DROP_CNT_WIDTH    = 32;

  // Which half of the output word the next accepted sample fills.
  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_e;

endpackage

// File: rtl/axis_fifo2.sv
// Two-entry shift FIFO; the head entry is a register so downstream data is
// driven straight from a flop. A push is honoured when not full, or when a
// pop happens in the same cycle.
module axis_fifo2
  import axis_sample_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = M_TDATA_WIDTH_DEF
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [FIFO_CNT_WIDTH-1:0] count,
  output logic [DATA_WIDTH-1:0]     data
);

  logic [DATA_WIDTH-1:0]     entry1;
  logic                      do_pop_c;
  logic                      do_push_c;
  logic [FIFO_CNT_WIDTH-1:0] count_nxt_c;

  // Qualify push/pop against occupancy and compute the next fill level.
  always_comb begin
    do_pop_c    = 1'b0;
    do_push_c   = 1'b0;
    count_nxt_c = count;
    do_pop_c    = pop & ~empty;
    do_push_c   = push & (~full | do_pop_c);
    case ({do_push_c, do_pop_c})
      2'b10:   count_nxt_c = count + FIFO_CNT_WIDTH'(1);
      2'b01:   count_nxt_c = count - FIFO_CNT_WIDTH'(1);
      default: count_nxt_c = count;
    endcase
  end

  // Occupancy flags and entry storage; entries shift toward the head on pop.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      data   <= '0;
      entry1 <= '0;
    end else begin
      count <= count_nxt_c;
      full  <= (count_nxt_c == FIFO_CNT_WIDTH'(FIFO_DEPTH));
      empty <= (count_nxt_c == '0);
      if (do_pop_c) begin
        if (full) begin
          data <= entry1;
          if (do_push_c) begin
            entry1 <= push_data;
          end
        end else if (do_push_c) begin
          data <= push_data;
        end
      end else if (do_push_c) begin
        if (empty) begin
          data <= push_data;
        end else begin
          entry1 <= push_data;
        end
      end
    end
  end

endmodule

// File: rtl/axis_sample_packer.sv
// Packs pairs of ADC samples into double-width AXI-Stream words for the DDR
// writer. The ADC cannot stall, so completed words that find the 2-entry
// buffer full (with no transfer that cycle) are dropped and flagged.
// Optional feature: define AXIS_SAMPLE_PACKER_DROP_CNT_EN to add the
// saturating sts_drop_count output.
module axis_sample_packer
  import axis_sample_pkg::*;
#(
  parameter int unsigned S_TDATA_WIDTH = S_TDATA_WIDTH_DEF,
  parameter int unsigned M_TDATA_WIDTH = M_TDATA_WIDTH_DEF,  // must be 2*S_TDATA_WIDTH
  parameter int unsigned CNT_WIDTH     = 64
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     cfg_enable,
  input  logic [S_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [M_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [CNT_WIDTH-1:0]     sts_word_count,
  output logic                     sts_overflow
`ifdef AXIS_SAMPLE_PACKER_DROP_CNT_EN
  ,
  output logic [DROP_CNT_WIDTH-1:0] sts_drop_count
`endif
);

  phase_e                    phase_q;
  phase_e                    phase_d;
  logic [S_TDATA_WIDTH-1:0]  sample_lo;
  logic                      en_q;
  logic                      lo_load_c;
  logic                      complete_c;
  logic                      pop_c;
  logic                      push_c;
  logic                      drop_c;
  logic                      rise_c;
  logic                      space_c;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [FIFO_CNT_WIDTH-1:0] fifo_count;
  logic [M_TDATA_WIDTH-1:0]  push_data_c;

  assign s_axis_tready = 1'b1;
  assign m_axis_tvalid = ~fifo_empty;
  assign push_data_c   = M_TDATA_WIDTH'({s_axis_tdata, sample_lo});

  // Phase state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase_q <= PH_LO;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Next phase plus per-cycle accept/complete/push/drop decisions.
  always_comb begin
    phase_d    = phase_q;
    lo_load_c  = 1'b0;
    complete_c = 1'b0;
    pop_c      = m_axis_tvalid & m_axis_tready;
    rise_c     = cfg_enable & ~en_q;
    space_c    = (fifo_count < FIFO_CNT_WIDTH'(FIFO_DEPTH));
    if (!cfg_enable) begin
      phase_d = PH_LO;
    end else if (s_axis_tvalid) begin
      case (phase_q)
        PH_LO: begin
          phase_d   = PH_HI;
          lo_load_c = 1'b1;
        end
        PH_HI: begin
          phase_d    = PH_LO;
          complete_c = 1'b1;
        end
        default: phase_d = PH_LO;
      endcase
    end
    push_c = complete_c & (space_c | pop_c);
    drop_c = complete_c & fifo_full & ~pop_c;
  end

  // Hold the low-half sample and the enable history.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sample_lo <= '0;
      en_q      <= 1'b0;
    end else begin
      en_q <= cfg_enable;
      if (lo_load_c) begin
        sample_lo <= s_axis_tdata;
      end
    end
  end

  // Delivered-word counter and sticky overflow flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sts_word_count <= '0;
      sts_overflow   <= 1'b0;
    end else begin
      if (pop_c) begin
        sts_word_count <= sts_word_count + CNT_WIDTH'(1);
      end
      if (rise_c) begin
        sts_overflow <= 1'b0;
      end else if (drop_c) begin
        sts_overflow <= 1'b1;
      end
    end
  end

`ifdef AXIS_SAMPLE_PACKER_DROP_CNT_EN
  // Saturating dropped-word counter, cleared together with the overflow flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sts_drop_count <= '0;
    end else if (rise_c) begin
      sts_drop_count <= '0;
    end else if (drop_c && (sts_drop_count != '1)) begin
      sts_drop_count <= sts_drop_count + DROP_CNT_WIDTH'(1);
    end
  end
`endif

  axis_fifo2 #(
    .DATA_WIDTH (M_TDATA_WIDTH)
  ) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (push_c),
    .push_data (push_data_c),
    .pop       (pop_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .data      (m_axis_tdata)
  );

endmodule

// File: tb/tb_axis_sample_packer.sv
// Bench for axis_sample_packer: directed vectors, a queue-based model of the
// packer checked every cycle, and hand-computed literal expectations.
module tb_axis_sample_packer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [63:0] sts_word_count;
  logic        sts_overflow;
`ifdef AXIS_SAMPLE_PACKER_DROP_CNT_EN
  logic [31:0] sts_drop_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 aclk = ~aclk;

  axis_sample_packer #(
    .S_TDATA_WIDTH (32),
    .M_TDATA_WIDTH (64),
    .CNT_WIDTH     (64)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .cfg_enable     (cfg_enable),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .sts_word_count (sts_word_count),
    .sts_overflow   (sts_overflow)
`ifdef AXIS_SAMPLE_PACKER_DROP_CNT_EN
    ,
    .sts_drop_count (sts_drop_count)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words waiting downstream in a queue, half word as a flag + value.
  logic [63:0] mq[$];
  logic [31:0] m_half;
  bit          m_have;
  bit          m_en_prev;
  logic [63:0] m_cnt;
  bit          m_ovf;
  logic [31:0] m_drops;
  bit          md_xfer;
  bit          md_done;
  logic [63:0] md_word;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mq.delete();
      m_half    = '0;
      m_have    = 1'b0;
      m_en_prev = 1'b0;
      m_cnt     = '0;
      m_ovf     = 1'b0;
      m_drops   = '0;
    end else begin
      md_xfer = (mq.size() > 0) && m_axis_tready;
      md_done = 1'b0;
      md_word = '0;
      if (!cfg_enable) m_have = 1'b0;
      if (cfg_enable && !m_en_prev) begin
        m_ovf   = 1'b0;
        m_drops = '0;
      end
      if (cfg_enable && s_axis_tvalid) begin
        if (!m_have) begin
          m_half = s_axis_tdata;
          m_have = 1'b1;
        end else begin
          md_word = {s_axis_tdata, m_half};
          m_have  = 1'b0;
          md_done = 1'b1;
        end
      end
      if (md_xfer) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 64'd1;
      end
      if (md_done) begin
        if (mq.size() < 2) begin
          mq.push_back(md_word);
        end else begin
          m_ovf = 1'b1;
          if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 32'd1;
        end
      end
      m_en_prev = cfg_enable;
    end
  end

  // Compare DUT outputs against the model every falling edge.
  always @(negedge aclk) begin
    check("tvalid", 64'(m_axis_tvalid), 64'(mq.size() > 0));
    if (mq.size() > 0) check("tdata", m_axis_tdata, mq[0]);
    check("word_count", sts_word_count, m_cnt);
    check("overflow", 64'(sts_overflow), 64'(m_ovf));
    check("s_tready", 64'(s_axis_tready), 64'd1);
`ifdef AXIS_SAMPLE_PACKER_DROP_CNT_EN
    check("drop_count", 64'(sts_drop_count), 64'(m_drops));
`endif
  end

  // One clock: drive on the falling edge, return just after the rising edge.
  task automatic cyc(input logic en, input logic v, input logic [31:0] d, input logic r);
    @(negedge aclk);
    cfg_enable    = en;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    m_axis_tready = r;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge aclk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_count", sts_word_count, 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd1);
    aresetn = 1'b1;

    // Basic pack with downstream ready.
    cyc(1'b1, 1'b1, 32'h1111_1111, 1'b1);
    check("basic_no_word_yet", 64'(m_axis_tvalid), 64'd0);
    cyc(1'b1, 1'b1, 32'h2222_2222, 1'b1);
    check("basic_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("basic_tdata", m_axis_tdata, 64'h2222_2222_1111_1111);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    check("basic_count", sts_word_count, 64'd1);
    check("basic_drained", 64'(m_axis_tvalid), 64'd0);

    // Stall: three words, the third dropped.
    for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b1, 32'hA000_0000 + 32'(i), 1'b0);
    check("stall_head", m_axis_tdata, 64'hA000_0002_A000_0001);
    check("stall_ovf", 64'(sts_overflow), 64'd1);
`ifdef AXIS_SAMPLE_PACKER_DROP_CNT_EN
    check("stall_drops", 64'(sts_drop_count), 64'd1);
`endif
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("stall_second", m_axis_tdata, 64'hA000_0004_A000_0003);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("stall_empty", 64'(m_axis_tvalid), 64'd0);
    check("stall_count", sts_word_count, 64'd3);
    check("stall_ovf_sticky", 64'(sts_overflow), 64'd1);

    // Enable toggle discards the half sample and clears overflow.
    cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b1, 32'h0000_AAAA, 1'b1);
    check("toggle_ovf_clr", 64'(sts_overflow), 64'd0);
    cyc(1'b1, 1'b1, 32'h0000_BBBB, 1'b1);
    check("toggle_word", m_axis_tdata, 64'h0000_BBBB_0000_AAAA);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    check("toggle_count", sts_word_count, 64'd4);

    // Full FIFO: completion and transfer in the same cycle.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b1, 32'hB000_0000 + 32'(i), 1'b0);
    cyc(1'b1, 1'b1, 32'hB000_0006, 1'b1);
    check("same_cycle_ovf", 64'(sts_overflow), 64'd0);
    check("same_cycle_head", m_axis_tdata, 64'hB000_0004_B000_0003);
    check("same_cycle_count", sts_word_count, 64'd5);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    check("same_cycle_last", m_axis_tdata, 64'hB000_0006_B000_0005);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    check("same_cycle_count2", sts_word_count, 64'd7);

    // Reset mid-stream with two words buffered.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, 32'hC000_0000 + 32'(i), 1'b0);
    check("prereset_tvalid", 64'(m_axis_tvalid), 64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("reset_tdata", m_axis_tdata, 64'd0);
    check("reset_count", sts_word_count, 64'd0);
    check("reset_ovf", 64'(sts_overflow), 64'd0);
`ifdef AXIS_SAMPLE_PACKER_DROP_CNT_EN
    check("reset_drops", 64'(sts_drop_count), 64'd0);
`endif
    @(negedge aclk);
    @(negedge aclk);
    aresetn       = 1'b1;
    cfg_enable    = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hD000_0001;
    m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;
    cyc(1'b1, 1'b1, 32'hD000_0002, 1'b1);
    check("post_reset_word", m_axis_tdata, 64'hD000_0002_D000_0001);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    check("post_reset_count", sts_word_count, 64'd1);

    repeat (2) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_sample_packer.md
AXIS_SAMPLE_PACKER -- requirements
Module: axis_sample_packer

Interface
REQ-001 SHALL have parameter S_TDATA_WIDTH, default 32, meaning input sample width (one 2-channel ADC sample).
REQ-002 SHALL have parameter M_TDATA_WIDTH, default 64, fixed at 2*S_TDATA_WIDTH; the packed output word feeds the DDR RAM writer.
REQ-003 SHALL have parameter CNT_WIDTH, default 64, meaning width of the output word counter.
REQ-004 SHALL use one clock; reset is asynchronous and active-low. Ports: aclk  in  1  system clock; aresetn  in  1  async active-low reset.
REQ-005 SHALL have port cfg_enable  in  1  acquisition enable, level-sensitive.
REQ-006 SHALL have ports s_axis_tdata  in  S_TDATA_WIDTH  input sample; s_axis_tvalid  in  1  sample valid; s_axis_tready  out  1  tied high, because the ADC cannot stall.
REQ-007 SHALL have ports m_axis_tdata  out  M_TDATA_WIDTH  packed word; m_axis_tvalid  out  1; m_axis_tready  in  1.
REQ-008 SHALL have ports sts_word_count  out  CNT_WIDTH  words delivered downstream; sts_overflow  out  1  sticky drop flag.
REQ-009 SHALL have port sts_drop_count  out  32  dropped words, present only with AXIS_SAMPLE_PACKER_DROP_CNT_EN.

Function
REQ-010 SHALL accept a sample when s_axis_tvalid & cfg_enable; samples offered while cfg_enable=0 SHALL be discarded.
REQ-011 SHALL place the first accepted sample (phase 0) in bits [31:0] and the second (phase 1) in bits [63:32], then emit one word.
REQ-012 SHALL present the packed word on m_axis_* exactly 1 cycle after the phase-1 sample is accepted, if buffer space exists.
REQ-013 SHALL buffer completed words in a 2-entry FIFO, delivering them in completion order.
REQ-014 SHALL follow AXI-Stream rules: m_axis_tdata and m_axis_tvalid stable while tvalid=1 and tready=0; a transfer occurs on tvalid & tready.
REQ-015 SHALL drop a completed word when the FIFO holds 2 entries and no transfer occurs that cycle, and SHALL then set sts_overflow.
REQ-016 SHALL NOT drop a word when completion coincides with a downstream transfer on a full FIFO; pop and push happen in the same cycle.
REQ-017 SHALL, on cfg_enable falling, reset phase to 0 and discard any half-packed sample; buffered words SHALL continue to drain.
REQ-018 SHALL, on a cfg_enable rising edge (registered compare), clear sts_overflow and restart at phase 0; sts_word_count is not cleared.
REQ-019 SHALL increment sts_word_count by 1 per downstream transfer, wrapping modulo 2^CNT_WIDTH.
REQ-020 SHALL keep sts_overflow set until the next cfg_enable rising edge or reset.

Reset
REQ-021 SHALL, on aresetn=0 (asynchronous), clear: phase=0, FIFO empty, m_axis_tvalid=0, m_axis_tdata=0, sts_word_count=0, sts_overflow=0, sts_drop_count=0, enable history=0.
REQ-022 SHALL, on reset mid-operation, lose all buffered and partial data, and first accept samples in the cycle after aresetn rises.
REQ-023 SHALL keep s_axis_tready=1 during and after reset.

Configuration
REQ-024 SHALL, with AXIS_SAMPLE_PACKER_DROP_CNT_EN defined, provide sts_drop_count: +1 per dropped word, saturating at 2^32-1, cleared with sts_overflow.
REQ-025 SHALL, without AXIS_SAMPLE_PACKER_DROP_CNT_EN, omit the sts_drop_count port and its logic; all other behaviour is identical.

Structure
REQ-026 SHALL take S_TDATA_WIDTH/M_TDATA_WIDTH defaults and the FIFO depth constant (2) from shared package axis_sample_pkg.
REQ-027 SHALL implement the 2-entry buffer as sub-module axis_fifo2 (push, pop, full, empty, count, data), with valid/ready logic in axis_sample_packer.

Verification
REQ-028 SHALL test: enable=1, tready=1, samples 0x11111111, 0x22222222 -> one word 0x2222222211111111 one cycle later, sts_word_count=1.
REQ-029 SHALL test: tready=0, 6 samples -> 2 words held, 3rd dropped, sts_overflow=1, sts_drop_count=1 (macro on); tready=1 -> words 1,2 in order.
REQ-030 SHALL test: FIFO full, completion and transfer in the same cycle -> no drop, sts_overflow stays 0.
REQ-031 SHALL test: 1 sample, enable 1->0->1, then samples A, B -> output {B,A}, the first sample discarded, overflow cleared.
REQ-032 SHALL test: aresetn pulsed low mid-stream with 2 words buffered -> m_axis_tvalid=0 immediately and all counters 0.
